stream_xor_engine: RTL and testbench

STREAM_XOR_ENGINE -- requirements
Module: stream_xor_engine

---
 rtl/stream_xor_engine.sv | 126 ++++++++++++
 tb/tb_stream_xor_engine.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_xor_engine.sv
// stream_xor_engine: encrypts a byte stream one byte at a time by XORing each
// accepted plaintext byte with a keystream byte requested from a hash generator.
//
// Optional build macro: STREAM_XOR_TIMEOUT_EN adds a keystream watchdog that
// abandons a byte after TIMEOUT_CYCLES cycles in WAIT_KEY and sets timeout_err.
//
// Ports:
//   clk, nrst                 clock, asynchronous active-low reset
//   in_data/in_valid/in_ready plaintext input handshake
//   out_data/out_valid/out_ready ciphertext output handshake
//   request_hash_byte_pulse   one-cycle keystream request
//   hash_byte_in/hash_byte_pulse_in keystream byte and its one-cycle strobe
//   byte_count                bytes delivered since reset (wraps)
//   busy                      high whenever the FSM is not IDLE
//   timeout_err               sticky watchdog flag (0 when watchdog not built)
module stream_xor_engine #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        request_hash_byte_pulse,
    input  logic [7:0]  hash_byte_in,
    input  logic        hash_byte_pulse_in,
    output logic [31:0] byte_count,
    output logic        busy,
    output logic        timeout_err
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQUEST  = 2'd1,
        WAIT_KEY = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   data_q;

`ifdef STREAM_XOR_TIMEOUT_EN
    logic [CNT_W-1:0]    wait_cnt;
    // Last WAIT_KEY cycle: the counter reaches TIMEOUT_CYCLES at this edge.
    logic                wait_last_c;
    assign wait_last_c = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic                unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES) ^ ^32'(CNT_W);
    assign timeout_err = 1'b0;
`endif

    // FSM with all outputs registered alongside the state transition.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state                   <= IDLE;
            data_q                  <= '0;
            out_data                <= '0;
            out_valid               <= 1'b0;
            in_ready                <= 1'b1;
            request_hash_byte_pulse <= 1'b0;
            byte_count              <= '0;
            busy                    <= 1'b0;
`ifdef STREAM_XOR_TIMEOUT_EN
            wait_cnt                <= '0;
            timeout_err             <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q                  <= in_data;
                        state                   <= REQUEST;
                        in_ready                <= 1'b0;
                        busy                    <= 1'b1;
                        request_hash_byte_pulse <= 1'b1;
                    end
                end
                REQUEST: begin
                    state                   <= WAIT_KEY;
                    request_hash_byte_pulse <= 1'b0;
`ifdef STREAM_XOR_TIMEOUT_EN
                    wait_cnt                <= '0;
`endif
                end
                WAIT_KEY: begin
                    // A keystream pulse on the final watchdog cycle still wins.
                    if (hash_byte_pulse_in) begin
                        out_data  <= data_q ^ hash_byte_in;
                        out_valid <= 1'b1;
                        state     <= HOLD;
`ifdef STREAM_XOR_TIMEOUT_EN
                    end else if (wait_last_c) begin
                        timeout_err <= 1'b1;
                        data_q      <= '0;
                        state       <= IDLE;
                        in_ready    <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
`endif
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        byte_count <= byte_count + 32'd1;
                        state      <= IDLE;
                        in_ready   <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_xor_engine.sv
// Self-checking bench for stream_xor_engine: directed vector table, hand-written
// hold/spurious/reset/timeout sequences, and randomized transfers checked
// against a queue-based reference model.
module tb_stream_xor_engine;

    localparam int unsigned TO_CYC = 4;
`ifdef STREAM_XOR_TIMEOUT_EN
    localparam int KMAX = 2;
`else
    localparam int KMAX = 10;
`endif

    logic        clk;
    logic        nrst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        request_hash_byte_pulse;
    logic [7:0]  hash_byte_in;
    logic        hash_byte_pulse_in;
    logic [31:0] byte_count;
    logic        busy;
    logic        timeout_err;

    stream_xor_engine #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk                     (clk),
        .nrst                    (nrst),
        .in_data                 (in_data),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .out_data                (out_data),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .request_hash_byte_pulse (request_hash_byte_pulse),
        .hash_byte_in            (hash_byte_in),
        .hash_byte_pulse_in      (hash_byte_pulse_in),
        .byte_count              (byte_count),
        .busy                    (busy),
        .timeout_err             (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int          req_cnt = 0;
    int          ov_cnt  = 0;
    int unsigned exp_count = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors sample mid-cycle; a handshake seen here completes at the next edge.
    always @(negedge clk) begin
        if (nrst) begin
            if (request_hash_byte_pulse) req_cnt++;
            if (out_valid) ov_cnt++;
            if (out_valid && out_ready) got_q.push_back(out_data);
        end
    end

    // One full transfer: kdel = WAIT_KEY cycles before the key pulse,
    // rdel = HOLD cycles with out_ready low before it is raised.
    task automatic xfer(input logic [7:0] d, input logic [7:0] k, input int kdel, input int rdel);
        int         r0;
        int         v0;
        logic [7:0] expv;
        expv = d ^ k;
        r0 = req_cnt;
        v0 = ov_cnt;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom();
        chk("req_pulse", 32'(request_hash_byte_pulse), 32'd1);
        chk("req_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        for (int i = 0; i < kdel; i++) begin
            chk("wait_no_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        hash_byte_in       = k;
        hash_byte_pulse_in = 1'b1;
        @(negedge clk);
        hash_byte_pulse_in = 1'b0;
        hash_byte_in       = $urandom();
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(expv));
        for (int i = 0; i < rdel; i++) begin
            // Spurious keystream in HOLD must not disturb the output.
            if (i == 0) hash_byte_pulse_in = 1'b1;
            @(negedge clk);
            hash_byte_pulse_in = 1'b0;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(expv));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_count++;
        exp_q.push_back(expv);
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
        chk("byte_count", byte_count, 32'(exp_count));
        chk("req_per_byte", 32'(req_cnt - r0), 32'd1);
        chk("valid_cycles", 32'(ov_cnt - v0), 32'(rdel + 1));
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] key;
        int         kdel;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [7:0] d;
        logic [7:0] k;
        vecs[0] = '{din: 8'hA5, key: 8'h3C, kdel: 1, dout: 8'h99};
        vecs[1] = '{din: 8'h00, key: 8'h12, kdel: 0, dout: 8'h12};
        vecs[2] = '{din: 8'hFF, key: 8'h34, kdel: 2, dout: 8'hCB};
        vecs[3] = '{din: 8'h55, key: 8'h56, kdel: 1, dout: 8'h03};

        nrst = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        hash_byte_in = '0;
        hash_byte_pulse_in = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_req", 32'(request_hash_byte_pulse), 32'd0);
        chk("rst_count", byte_count, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // Directed vectors.
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b0;
            xfer(vecs[i].din, vecs[i].key, vecs[i].kdel, 0);
            chk("vec_out", 32'(exp_q[exp_q.size()-1]), 32'(vecs[i].dout));
        end

        // Spurious keystream in IDLE; out_ready high outside HOLD.
        hash_byte_in = 8'h77;
        hash_byte_pulse_in = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        hash_byte_pulse_in = 1'b0;
        out_ready = 1'b0;
        chk("spur_idle_ready", 32'(in_ready), 32'd1);
        chk("spur_idle_busy", 32'(busy), 32'd0);
        chk("spur_idle_data", 32'(out_data), 32'h03);
        chk("spur_idle_count", byte_count, 32'(exp_count));

        // Long HOLD stall.
        xfer(8'h3A, 8'hC5, 1, 10);

        // Randomized transfers.
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom());
            k = 8'($urandom());
            xfer(d, k, int'($urandom_range(0, KMAX)), int'($urandom_range(0, 3)));
        end

        // Delivered stream matches the model in order.
        chk("stream_len", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("stream_byte", 32'(got_q[i]), 32'(exp_q[i]));

`ifndef STREAM_XOR_TIMEOUT_EN
        // Without the watchdog the engine waits indefinitely for a key.
        xfer(8'h81, 8'h18, 100, 0);
        chk("no_watchdog_terr", 32'(timeout_err), 32'd0);
`endif

        // Reset during WAIT_KEY discards the byte.
        in_data = 8'hE7;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        nrst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_count", byte_count, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        #2;
        nrst = 1'b1;
        exp_count = 0;
        @(negedge clk);
        hash_byte_in = 8'hFF;
        hash_byte_pulse_in = 1'b1;
        @(negedge clk);
        hash_byte_pulse_in = 1'b0;
        chk("late_key_valid", 32'(out_valid), 32'd0);
        chk("late_key_data", 32'(out_data), 32'd0);
        chk("late_key_ready", 32'(in_ready), 32'd1);
        chk("late_key_req", 32'(request_hash_byte_pulse), 32'd0);

`ifdef STREAM_XOR_TIMEOUT_EN
        // No keystream: error after exactly TO_CYC WAIT_KEY cycles.
        in_data = 8'h42;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < int'(TO_CYC); i++) begin
            @(negedge clk);
            chk("to_pending_err", 32'(timeout_err), 32'd0);
            chk("to_pending_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_idle", 32'(in_ready), 32'd1);
        chk("to_count", byte_count, 32'(exp_count));
        // Key arriving on the last allowed cycle still delivers.
        xfer(8'h10, 8'h01, int'(TO_CYC) - 1, 0);
        chk("to_sticky", 32'(timeout_err), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
